// File: rtl/tank_level_encoder.sv
// tank_level_encoder
//   Reservoir model and three-probe sensor encoder. Integrates fill/drain
//   commands once per prescaler tick into a saturating water level, encodes
//   the level as the H/M/L thermometer code and qualifies it with ct once
//   the pattern has been stable for SETTLE ticks. fault_sel injects illegal
//   probe patterns (or freezes the level) for exercising the downstream
//   decoder.
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   fill_en    in   inlet valve open, sampled on tick
//   drain_en   in   irrigation pump on, sampled on tick
//   fault_sel  in   0 none, 1 H stuck-1, 2 L stuck-0, 3 freeze level
//   H, M, L    out  registered probe outputs
//   ct         out  probe pattern settled / valid
//   level      out  current level
//   overflow   out  1-cycle pulse when a tick was clipped at MAX_LEVEL
//   dry        out  level == 0
module tank_level_encoder #(
  parameter int LEVEL_W    = 8,
  parameter int MAX_LEVEL  = 200,
  parameter int L_TH       = 50,
  parameter int M_TH       = 100,
  parameter int H_TH       = 150,
  parameter int FILL_RATE  = 2,
  parameter int DRAIN_RATE = 1,
  parameter int TICK_DIV   = 1000,
  parameter int SETTLE     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fill_en,
  input  logic               drain_en,
  input  logic [1:0]         fault_sel,
  output logic               H,
  output logic               M,
  output logic               L,
  output logic               ct,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               dry
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ST_W  = $clog2(SETTLE + 1);
  localparam int SUM_W = LEVEL_W + 2;

  localparam logic signed [SUM_W-1:0] FILL_S  = SUM_W'(FILL_RATE);
  localparam logic signed [SUM_W-1:0] DRAIN_S = SUM_W'(DRAIN_RATE);
  localparam logic signed [SUM_W-1:0] MAX_S   = SUM_W'(MAX_LEVEL);

  typedef enum logic {SETTLING, VALID} state_e;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [2:0]         hml_q, hml_d;
  logic [ST_W-1:0]    settle_q, settle_d;
  state_e             state_q, state_d;
  logic signed [SUM_W-1:0] sum;

  // Prescaler
  always_comb begin
    tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Level integration; sum is signed so a drain below zero clips cleanly
  always_comb begin
    sum = $signed({2'b00, level_q})
        + (fill_en  ? FILL_S  : '0)
        - (drain_en ? DRAIN_S : '0);
    level_d    = level_q;
    overflow_d = 1'b0;
    if (tick && fault_sel != 2'd3) begin
      if (sum > MAX_S) begin
        level_d    = LEVEL_W'(MAX_LEVEL);
        overflow_d = 1'b1;
      end else if (sum < 0) begin
        level_d = '0;
      end else begin
        level_d = sum[LEVEL_W-1:0];
      end
    end
  end

  // Probe encoding from the registered level, then fault forcing
  always_comb begin
    hml_d = {level_q >= LEVEL_W'(H_TH),
             level_q >= LEVEL_W'(M_TH),
             level_q >= LEVEL_W'(L_TH)};
    if (fault_sel == 2'd1) hml_d[2] = 1'b1;
    if (fault_sel == 2'd2) hml_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      hml_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      hml_q      <= hml_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SETTLING;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // FSM: next state. Change is detected on hml_d so ct falls on the same
  // edge that the new pattern becomes visible on H/M/L.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (hml_d != hml_q) begin
      state_d  = SETTLING;
      settle_d = '0;
    end else if (state_q == SETTLING && tick) begin
      if (settle_q == ST_W'(SETTLE - 1)) begin
        state_d  = VALID;
        settle_d = '0;
      end else begin
        settle_d = settle_q + 1'b1;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    ct = (state_q == VALID);
  end

  assign H        = hml_q[2];
  assign M        = hml_q[1];
  assign L        = hml_q[0];
  assign level    = level_q;
  assign overflow = overflow_q;
  assign dry      = (level_q == '0);

endmodule
